fir_sop_pipe: RTL and testbench
===============================

// Module: fir_sop_pipe
// PURPOSE
//  Parametrised, fully pipelined sum-of-products (direct-form FIR) engine: y = sum_k C[k]*x[n-k].
//  Generalises the fixed 4-tap SOP datapath to TAPS taps with a runtime-writable coefficient
//  bank, valid-qualified streaming, a fixed-latency adder tree and an optional saturating output.
//  Sits between the sample source and downstream accumulation/scaling logic in the DSP lab chain.
// PARAMETERS
//  SIZE   4                          data and coefficient width (unsigned)
//  TAPS   4                          number of taps, >=2; need not be a power of 2
//  OUT_W  2*SIZE+$clog2(TAPS)        output width; the default is lossless
// PORTS
//  CLK        in   1       single clock, rising edge
//  RST        in   1       asynchronous, active-low reset
//  D_IN       in   SIZE    input sample
//  IN_VALID   in   1       D_IN is valid this cycle; the delay line advances only when high
//  COEF_WE    in   1       coefficient write strobe
//  COEF_ADDR  in   clog2(TAPS)  tap index for the write; out-of-range index ignored
//  COEF_DIN   in   SIZE    coefficient write data
//  OUT        out  OUT_W   filter output
//  OUT_VALID  out  1       OUT holds a valid result
// BEHAVIOUR
//  - Reset (RST=0, async): delay line, coefficient bank, all pipeline registers, OUT and
//    OUT_VALID are cleared to 0. Deassertion is not retimed here; it is synchronised upstream.
//  - Delay line: x[0..TAPS-1]. On an edge with IN_VALID=1, x[0]<=D_IN and x[k]<=x[k-1].
//    With IN_VALID=0 the line holds and no new result enters the pipe (bubble).
//  - Stage 1: products p[k]=x[k]*C[k] (2*SIZE bits) are registered for the new sample.
//  - Stages 2..: binary adder tree with clog2(TAPS) registered levels. An odd operand at a
//    level passes through a register, so every path has equal depth. Each level widens by 1 bit.
//  - Latency LAT = 2 + clog2(TAPS) edges from the accepting edge to OUT/OUT_VALID (4 for TAPS=4).
//    A LAT-deep valid shift register tracks bubbles; OUT_VALID=1 exactly LAT edges after each
//    IN_VALID=1. OUT holds its last value while OUT_VALID=0. Throughput is 1 sample/cycle.
//  - Coefficient write: C[COEF_ADDR]<=COEF_DIN on an edge with COEF_WE=1. If that edge also
//    accepts a sample, the stage-1 product uses the OLD coefficient. The new value applies from
//    the next accepting edge. Writes never stall streaming.
//  - Arithmetic is unsigned. The full-precision sum has width FW = 2*SIZE+clog2(TAPS).
//  - Reset mid-stream: all in-flight results are discarded and OUT_VALID drops at once.
//    The first output after reset reflects zero history (x[] = 0).
// CONFIGURATION
//  FIR_SOP_SAT_EN defined: when OUT_W<FW, a final sum > 2^OUT_W-1 is clamped to
//    2^OUT_W-1 (all ones). Saturation adds no latency.
//  FIR_SOP_SAT_EN undefined: OUT = sum[OUT_W-1:0] (modulo wrap).
//  When OUT_W>=FW the two builds are identical; OUT is zero-extended.
// STRUCTURE
//  - Shared package sop_pkg holds clog2 helper, FW/LAT/tree-depth localparam formulas,
//    and the level-width function (2*SIZE+level). Used by this block and its bench.
//  - Sub-module sop_tap: one delay register, coefficient register and registered multiplier,
//    instantiated TAPS times via generate. The adder tree is a generate loop in this module.
// TESTING (SIZE=4, TAPS=4 unless noted)
//  1 Reset: RST=0 mid-stream with valids in flight -> OUT=0, OUT_VALID=0 immediately;
//    first valid after release has x[]=0 history.
//  2 Impulse: C={1,2,3,4}, D_IN=1 then 0,0,0,0 with IN_VALID=1 ->
//    OUT_VALID rises 4 edges later, OUT=1,2,3,4,0 on consecutive cycles.
//  3 Bubbles: same impulse with IN_VALID toggling 1,0,1,0 -> results 1,2,3,4 appear only on
//    cycles with OUT_VALID=1, spaced 2 apart; OUT holds during gaps.
//  4 Coefficient write on an accepting edge: C[0] 1->5 written with D_IN=2 ->
//    that result uses C[0]=1 (OUT=2); the next sample 2 gives OUT=10 (+ other taps).
//  5 Saturation, OUT_W=9, all C=15, D_IN=15 steady -> sum 900;
//    with FIR_SOP_SAT_EN OUT=511, without OUT=388.
//  6 TAPS=5 (non-power-of-2), C=1 each, D_IN=1 steady -> LAT=5,
//    OUT ramps 1..5 then holds 5.

Source files
------------

// File: rtl/sop_pkg.sv
// rtl/sop_pkg.sv - width, latency and adder-tree shape helpers for the sum-of-products FIR
package sop_pkg;

    function automatic int sop_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int sop_depth(input int taps);
        return sop_clog2(taps);
    endfunction

    function automatic int sop_fw(input int size, input int taps);
        return 2 * size + sop_clog2(taps);
    endfunction

    function automatic int sop_lat(input int taps);
        return 2 + sop_clog2(taps);
    endfunction

    function automatic int sop_lvl_w(input int size, input int level);
        return 2 * size + level;
    endfunction

    // Node count at a tree level; level 0 is the product row.
    function automatic int sop_nodes(input int taps, input int level);
        int n;
        n = taps;
        for (int j = 0; j < level; j++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int sop_base(input int taps, input int level);
        int b;
        b = 0;
        for (int j = 0; j < level; j++) b += sop_nodes(taps, j);
        return b;
    endfunction

endpackage

// File: rtl/sop_tap.sv
// rtl/sop_tap.sv - one FIR tap: delay stage, coefficient register and registered product
module sop_tap #(
    parameter int SIZE = 4,
    parameter int AW   = 2,
    parameter int IDX  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [SIZE-1:0]   x_in,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [SIZE-1:0]   coef_din,
    output logic [SIZE-1:0]   x_q,
    output logic [2*SIZE-1:0] prod
);
    localparam int PW = 2 * SIZE;

    logic [SIZE-1:0] c_q;

    // The product is formed from the sample being shifted in and the coefficient
    // held before this edge, so a same-edge write only affects later samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            c_q  <= '0;
            prod <= '0;
        end else begin
            if (coef_we && (coef_addr == AW'(IDX))) c_q <= coef_din;
            if (in_valid) begin
                x_q  <= x_in;
                prod <= PW'(x_in) * PW'(c_q);
            end
        end
    end

endmodule

// File: rtl/fir_sop_pipe.sv
// rtl/fir_sop_pipe.sv - pipelined TAPS-tap sum-of-products FIR; FIR_SOP_SAT_EN selects saturating narrow output
module fir_sop_pipe
    import sop_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int TAPS  = 4,
    parameter int OUT_W = 2 * SIZE + $clog2(TAPS)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [SIZE-1:0]            D_IN,
    input  logic                       IN_VALID,
    input  logic                       COEF_WE,
    input  logic [sop_clog2(TAPS)-1:0] COEF_ADDR,
    input  logic [SIZE-1:0]            COEF_DIN,
    output logic [OUT_W-1:0]           OUT,
    output logic                       OUT_VALID
);
    localparam int AW   = sop_clog2(TAPS);
    localparam int D    = sop_depth(TAPS);
    localparam int FW   = sop_fw(SIZE, TAPS);
    localparam int LAT  = sop_lat(TAPS);
    localparam int NSUM = sop_base(TAPS, D + 1) - TAPS;
    localparam int ROOT = NSUM - 1;

    logic [SIZE-1:0]   x_chain [0:TAPS];
    logic [2*SIZE-1:0] prod    [0:TAPS-1];
    logic [FW-1:0]     sum_q   [0:NSUM-1];
    logic [LAT-2:0]    vld_q;
    logic [OUT_W-1:0]  out_next;

    assign x_chain[0] = D_IN;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        sop_tap #(
            .SIZE (SIZE),
            .AW   (AW),
            .IDX  (k)
        ) u_tap (
            .clk       (CLK),
            .rst_n     (RST),
            .in_valid  (IN_VALID),
            .x_in      (x_chain[k]),
            .coef_we   (COEF_WE),
            .coef_addr (COEF_ADDR),
            .coef_din  (COEF_DIN),
            .x_q       (x_chain[k+1]),
            .prod      (prod[k])
        );
    end

    // Tree levels are stored flat in sum_q; an odd trailing node is registered
    // unchanged so every path sees the same number of stages.
    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int NP = sop_nodes(TAPS, l - 1);
        localparam int NC = sop_nodes(TAPS, l);
        localparam int BC = sop_base(TAPS, l) - TAPS;
        localparam int LW = sop_lvl_w(SIZE, l);

        for (genvar i = 0; i < NC; i++) begin : g_node
            logic [LW-1:0] node_sum;

            if (l == 1) begin : g_leaf
                if (2 * i + 1 < NP) begin : g_add
                    assign node_sum = LW'(prod[2*i]) + LW'(prod[2*i+1]);
                end else begin : g_pass
                    assign node_sum = LW'(prod[2*i]);
                end
            end else begin : g_inner
                localparam int BP = sop_base(TAPS, l - 1) - TAPS;
                if (2 * i + 1 < NP) begin : g_add
                    assign node_sum = LW'(sum_q[BP+2*i]) + LW'(sum_q[BP+2*i+1]);
                end else begin : g_pass
                    assign node_sum = LW'(sum_q[BP+2*i]);
                end
            end

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) sum_q[BC+i] <= '0;
                else      sum_q[BC+i] <= FW'(node_sum);
            end
        end
    end

    if (OUT_W < FW) begin : g_narrow
`ifdef FIR_SOP_SAT_EN
        assign out_next = (|sum_q[ROOT][FW-1:OUT_W]) ? {OUT_W{1'b1}} : sum_q[ROOT][OUT_W-1:0];
`else
        assign out_next = sum_q[ROOT][OUT_W-1:0];
`endif
    end else begin : g_wide
        assign out_next = OUT_W'(sum_q[ROOT]);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q     <= '0;
            OUT_VALID <= 1'b0;
            OUT       <= '0;
        end else begin
            vld_q     <= {vld_q[LAT-3:0], IN_VALID};
            OUT_VALID <= vld_q[LAT-2];
            if (vld_q[LAT-2]) OUT <= out_next;
        end
    end

endmodule

// File: tb/tb_fir_sop_pipe.sv
// tb/tb_fir_sop_pipe.sv - directed bench for fir_sop_pipe (4-tap, 9-bit-output and 5-tap instances)
module tb_fir_sop_pipe;
    import sop_pkg::*;

    localparam int FW_A = sop_fw(4, 4);
    localparam int FW_F = sop_fw(4, 5);

    logic            CLK;
    logic            RST;
    logic [3:0]      d_in;
    logic            in_valid;
    logic [3:0]      coef_din;
    logic            we_a, we_n, we_f;
    logic [1:0]      addr_a, addr_n;
    logic [2:0]      addr_f;
    logic [FW_A-1:0] out_a;
    logic [8:0]      out_n;
    logic [FW_F-1:0] out_f;
    logic            ov_a, ov_n, ov_f;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       we;
        logic [1:0] a;
        logic [3:0] c;
        logic       ov;
        logic [9:0] out;
    } vec_t;

    vec_t tbl [0:25];

    fir_sop_pipe #(.SIZE(4), .TAPS(4)) u_dut_a (
        .CLK(CLK), .RST(RST), .D_IN(d_in), .IN_VALID(in_valid),
        .COEF_WE(we_a), .COEF_ADDR(addr_a), .COEF_DIN(coef_din),
        .OUT(out_a), .OUT_VALID(ov_a)
    );

    fir_sop_pipe #(.SIZE(4), .TAPS(4), .OUT_W(9)) u_dut_n (
        .CLK(CLK), .RST(RST), .D_IN(d_in), .IN_VALID(in_valid),
        .COEF_WE(we_n), .COEF_ADDR(addr_n), .COEF_DIN(coef_din),
        .OUT(out_n), .OUT_VALID(ov_n)
    );

    fir_sop_pipe #(.SIZE(4), .TAPS(5)) u_dut_f (
        .CLK(CLK), .RST(RST), .D_IN(d_in), .IN_VALID(in_valid),
        .COEF_WE(we_f), .COEF_ADDR(addr_f), .COEF_DIN(coef_din),
        .OUT(out_f), .OUT_VALID(ov_f)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int inst, input int a, input int v);
        coef_din = 4'(v);
        case (inst)
            0:       begin we_a = 1'b1; addr_a = 2'(a); end
            1:       begin we_n = 1'b1; addr_n = 2'(a); end
            default: begin we_f = 1'b1; addr_f = 3'(a); end
        endcase
        tick();
        we_a = 1'b0;
        we_n = 1'b0;
        we_f = 1'b0;
    endtask

    function automatic vec_t mk(input int v, input int d, input int we, input int a,
                                input int c, input int ov, input int out);
        vec_t r;
        r.v = 1'(v); r.d = 4'(d); r.we = 1'(we); r.a = 2'(a); r.c = 4'(c);
        r.ov = 1'(ov); r.out = 10'(out);
        return r;
    endfunction

    function automatic int narrow_exp(input int n);
        int s;
        s = 225 * n;
`ifdef FIR_SOP_SAT_EN
        return (s > 511) ? 511 : s;
`else
        return s % 512;
`endif
    endfunction

    initial begin
        RST = 1'b0; d_in = '0; in_valid = 1'b0; coef_din = '0;
        we_a = 1'b0; we_n = 1'b0; we_f = 1'b0;
        addr_a = '0; addr_n = '0; addr_f = '0;

        repeat (3) tick();
        check("rst_out_a", out_a, 0);
        check("rst_ov_a", ov_a, 0);
        check("rst_out_n", out_n, 0);
        check("rst_ov_n", ov_n, 0);
        check("rst_out_f", out_f, 0);
        check("rst_ov_f", ov_f, 0);
        RST = 1'b1;

        for (int k = 0; k < 4; k++) wr(0, k, k + 1);

        // impulse, bubbled impulse, then a coefficient write on an accepting edge
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 1);
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 2);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 3);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 4);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 7, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 9, 0, 0, 0, 1, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 2);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 2);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 3);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 3);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 4);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 4);
        tbl[20] = mk(1, 2, 1, 0, 5, 0, 4);
        tbl[21] = mk(1, 2, 0, 0, 0, 0, 4);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 4);
        tbl[23] = mk(0, 0, 0, 0, 0, 1, 2);
        tbl[24] = mk(0, 0, 0, 0, 0, 1, 14);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 14);

        for (int i = 0; i < 26; i++) begin
            in_valid = tbl[i].v;
            d_in     = tbl[i].d;
            we_a     = tbl[i].we;
            addr_a   = tbl[i].a;
            coef_din = tbl[i].c;
            tick();
            check($sformatf("vec%0d_ov", i), ov_a, tbl[i].ov);
            check($sformatf("vec%0d_out", i), out_a, tbl[i].out);
        end
        we_a = 1'b0;

        // reset asserted between edges with results in flight
        in_valid = 1'b1;
        d_in     = 4'd3;
        repeat (6) tick();
        check("pre_rst_ov", ov_a, 1);
        check("pre_rst_out", out_a, 38);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_out_a", out_a, 0);
        check("mid_rst_ov_a", ov_a, 0);
        check("mid_rst_ov_n", ov_n, 0);
        check("mid_rst_ov_f", ov_f, 0);
        in_valid = 1'b0;
        tick();
        tick();
        RST = 1'b1;

        in_valid = 1'b1;
        d_in     = 4'd1;
        tick();
        in_valid = 1'b0;
        d_in     = 4'd0;
        check("post_rst_ov1", ov_a, 0);
        tick();
        check("post_rst_ov2", ov_a, 0);
        tick();
        check("post_rst_ov3", ov_a, 0);
        tick();
        check("post_rst_ov4", ov_a, 1);
        check("post_rst_coef_cleared", out_a, 0);

        for (int k = 0; k < 4; k++) wr(0, k, k + 1);
        in_valid = 1'b1;
        d_in     = 4'd0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("post_rst_hist_ov", ov_a, 1);
        check("post_rst_hist_out", out_a, 2);

        // 9-bit output: full sum reaches 900
        for (int k = 0; k < 4; k++) wr(1, k, 15);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            d_in     = (i < 4) ? 4'd0 : 4'd15;
            tick();
            if (i >= 6) begin
                check($sformatf("narrow%0d_ov", i), ov_n, 1);
                check($sformatf("narrow%0d_out", i), out_n,
                      narrow_exp((i - 6 > 4) ? 4 : i - 6));
            end
        end
        in_valid = 1'b0;

        // 5 taps; writes to indices 5 and 7 must be dropped
        for (int k = 0; k < 5; k++) wr(2, k, 1);
        wr(2, 5, 9);
        wr(2, 7, 9);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            d_in     = (i < 5) ? 4'd0 : 4'd1;
            tick();
            if (i >= 8) begin
                check($sformatf("taps5_%0d_ov", i), ov_f, 1);
                check($sformatf("taps5_%0d_out", i), out_f, (i - 8 > 5) ? 5 : i - 8);
            end
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
